// File: rtl/pipe_pkg.sv
// Shared constants for the fetch/decode front end: opcodes, the NOP word,
// hold lengths and the fetch-control state encoding.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Number of bubbles inserted behind each hazard class.
  localparam logic [1:0] HCNT_BRANCH = 2'd2;
  localparam logic [1:0] HCNT_SHORT  = 2'd1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] word);
    return word[5:0];
  endfunction

endpackage

// File: rtl/pipe_fetch_ctrl_if.sv
// Bundle between the instruction fetch path and the fetch controller:
// fetched word/PC+4 in, decoded flags and pipeline registers out.
interface pipe_fetch_if;

  logic [31:0] instr_IF;
  logic [31:0] PC_plus_four_IF;

  logic        BEQ_IF, BNE_IF, J_IF, JAL_IF, JR_IF, LW_IF;
  logic        BEQ_RF, BNE_RF, JR_RF;
  logic        BEQ_EX, BNE_EX;
  logic [31:0] IR_RF, IR_EX;
  logic [31:0] PC4_RF;
  logic [15:0] imm_EX;

  modport master (
    output instr_IF, PC_plus_four_IF,
    input  BEQ_IF, BNE_IF, J_IF, JAL_IF, JR_IF, LW_IF,
    input  BEQ_RF, BNE_RF, JR_RF, BEQ_EX, BNE_EX,
    input  IR_RF, IR_EX, PC4_RF, imm_EX
  );

  modport slave (
    input  instr_IF, PC_plus_four_IF,
    output BEQ_IF, BNE_IF, J_IF, JAL_IF, JR_IF, LW_IF,
    output BEQ_RF, BNE_RF, JR_RF, BEQ_EX, BNE_EX,
    output IR_RF, IR_EX, PC4_RF, imm_EX
  );

endinterface

// File: rtl/pipe_if_decode.sv
// Combinational opcode/funct decode of one instruction word into the six
// control-flow / load flags used by the fetch controller.
module pipe_if_decode
  import pipe_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        beq_o,
  output logic        bne_o,
  output logic        j_o,
  output logic        jal_o,
  output logic        jr_o,
  output logic        lw_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_fields;

  assign op = opcode_of(instr_i);
  assign fn = funct_of(instr_i);
  assign unused_fields = ^instr_i[25:6];

  assign beq_o = (op == OP_BEQ);
  assign bne_o = (op == OP_BNE);
  assign j_o   = (op == OP_J);
  assign jal_o = (op == OP_JAL);
  assign jr_o  = (op == OP_RTYPE) && (fn == FN_JR);
  assign lw_o  = (op == OP_LW);

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// Fetch controller: captures IF into the RF/EX pipeline registers and inserts
// NOP bubbles behind branches (2) and JR/LW (1) while the fetch is held.
module pipe_fetch_ctrl
  import pipe_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  pipe_fetch_if.slave  bus
);

  state_e      state_q, state_d;
  logic [1:0]  hcnt_q, hcnt_d;
  logic [31:0] ir_rf_q, ir_rf_d;
  logic [31:0] pc4_rf_q, pc4_rf_d;
  logic        beq_rf_q, beq_rf_d;
  logic        bne_rf_q, bne_rf_d;
  logic        jr_rf_q, jr_rf_d;
  logic [31:0] ir_ex_q;
  logic        beq_ex_q, bne_ex_q;

  logic dec_beq, dec_bne, dec_j, dec_jal, dec_jr, dec_lw;
  logic run;

  pipe_if_decode u_if_decode (
    .instr_i (bus.instr_IF),
    .beq_o   (dec_beq),
    .bne_o   (dec_bne),
    .j_o     (dec_j),
    .jal_o   (dec_jal),
    .jr_o    (dec_jr),
    .lw_o    (dec_lw)
  );

  assign run = (state_q == ST_RUN);

  // The word re-presented during HOLD must not look like a live instruction.
  assign bus.BEQ_IF = dec_beq & run;
  assign bus.BNE_IF = dec_bne & run;
  assign bus.J_IF   = dec_j   & run;
  assign bus.JAL_IF = dec_jal & run;
  assign bus.JR_IF  = dec_jr  & run;
  assign bus.LW_IF  = dec_lw  & run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      hcnt_q   <= 2'd0;
      ir_rf_q  <= NOP_WORD;
      pc4_rf_q <= 32'h0;
      beq_rf_q <= 1'b0;
      bne_rf_q <= 1'b0;
      jr_rf_q  <= 1'b0;
      ir_ex_q  <= NOP_WORD;
      beq_ex_q <= 1'b0;
      bne_ex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      ir_rf_q  <= ir_rf_d;
      pc4_rf_q <= pc4_rf_d;
      beq_rf_q <= beq_rf_d;
      bne_rf_q <= bne_rf_d;
      jr_rf_q  <= jr_rf_d;
      ir_ex_q  <= ir_rf_q;
      beq_ex_q <= beq_rf_q;
      bne_ex_q <= bne_rf_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    ir_rf_d  = NOP_WORD;
    pc4_rf_d = pc4_rf_q;
    beq_rf_d = 1'b0;
    bne_rf_d = 1'b0;
    jr_rf_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        ir_rf_d  = bus.instr_IF;
        pc4_rf_d = bus.PC_plus_four_IF;
        beq_rf_d = dec_beq;
        bne_rf_d = dec_bne;
        jr_rf_d  = dec_jr;
        if (dec_beq || dec_bne) begin
          state_d = ST_HOLD;
          hcnt_d  = HCNT_BRANCH;
        end else if (dec_jr || dec_lw) begin
          state_d = ST_HOLD;
          hcnt_d  = HCNT_SHORT;
        end
      end
      ST_HOLD: begin
        hcnt_d = hcnt_q - 2'd1;
        if (hcnt_q == 2'd1) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        hcnt_d  = 2'd0;
      end
    endcase
  end

  assign bus.BEQ_RF = beq_rf_q;
  assign bus.BNE_RF = bne_rf_q;
  assign bus.JR_RF  = jr_rf_q;
  assign bus.BEQ_EX = beq_ex_q;
  assign bus.BNE_EX = bne_ex_q;
  assign bus.IR_RF  = ir_rf_q;
  assign bus.IR_EX  = ir_ex_q;
  assign bus.PC4_RF = pc4_rf_q;
  assign bus.imm_EX = ir_ex_q[15:0];

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Directed bench for pipe_fetch_ctrl: hazard bubbles, latency, jumps,
// back-to-back branches and asynchronous reset in the middle of a hold.
module tb_pipe_fetch_ctrl;

  localparam logic [31:0] W_BEQ = 32'h1022_0003;
  localparam logic [31:0] W_BNE = 32'h1422_0005;
  localparam logic [31:0] W_JR  = 32'h03E0_0008;
  localparam logic [31:0] W_LW  = 32'h8C22_0004;
  localparam logic [31:0] W_JAL = 32'h0C00_0010;
  localparam logic [31:0] W_J   = 32'h0800_0040;
  localparam logic [31:0] W_ADD = 32'h0022_1820;
  localparam logic [31:0] W_UND = 32'hFC00_1234;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  pipe_fetch_if bus ();

  pipe_fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic [31:0] pc4);
    bus.instr_IF = w;
    bus.PC_plus_four_IF = pc4;
    #1;
  endtask

  task automatic test_reset();
    drive(W_ADD, 32'h0000_0004);
    tick();
    tick();
    n_cmp++; if (bus.IR_RF !== 32'h0) begin n_bad++; $display("FAIL reset_ir_rf: got %h want %h", bus.IR_RF, 32'h0); end
    n_cmp++; if (bus.IR_EX !== 32'h0) begin n_bad++; $display("FAIL reset_ir_ex: got %h want %h", bus.IR_EX, 32'h0); end
    n_cmp++; if (bus.PC4_RF !== 32'h0) begin n_bad++; $display("FAIL reset_pc4: got %h want %h", bus.PC4_RF, 32'h0); end
    n_cmp++; if ({bus.BEQ_RF, bus.BNE_RF, bus.JR_RF, bus.BEQ_EX, bus.BNE_EX} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00000", {bus.BEQ_RF, bus.BNE_RF, bus.JR_RF, bus.BEQ_EX, bus.BNE_EX});
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_beq();
    drive(W_BEQ, 32'h0000_0100);
    n_cmp++; if (bus.BEQ_IF !== 1'b1) begin n_bad++; $display("FAIL beq_if_c0: got %b want 1", bus.BEQ_IF); end
    tick();
    drive(W_BNE, 32'h0000_0104);
    n_cmp++; if (bus.IR_RF !== W_BEQ) begin n_bad++; $display("FAIL beq_ir_rf_c1: got %h want %h", bus.IR_RF, W_BEQ); end
    n_cmp++; if (bus.BEQ_RF !== 1'b1) begin n_bad++; $display("FAIL beq_rf_c1: got %b want 1", bus.BEQ_RF); end
    n_cmp++; if ({bus.BEQ_IF, bus.BNE_IF} !== 2'b00) begin n_bad++; $display("FAIL beq_if_masked_c1: got %b want 00", {bus.BEQ_IF, bus.BNE_IF}); end
    n_cmp++; if (bus.PC4_RF !== 32'h0000_0100) begin n_bad++; $display("FAIL beq_pc4_c1: got %h want %h", bus.PC4_RF, 32'h100); end
    tick();
    n_cmp++; if (bus.BEQ_EX !== 1'b1) begin n_bad++; $display("FAIL beq_ex_c2: got %b want 1", bus.BEQ_EX); end
    n_cmp++; if (bus.imm_EX !== 16'h0003) begin n_bad++; $display("FAIL beq_imm_c2: got %h want 0003", bus.imm_EX); end
    n_cmp++; if (bus.IR_RF !== 32'h0) begin n_bad++; $display("FAIL beq_nop_c2: got %h want 0", bus.IR_RF); end
    n_cmp++; if (bus.BEQ_RF !== 1'b0) begin n_bad++; $display("FAIL beq_rf_c2: got %b want 0", bus.BEQ_RF); end
    n_cmp++; if (bus.BNE_IF !== 1'b0) begin n_bad++; $display("FAIL beq_if_masked_c2: got %b want 0", bus.BNE_IF); end
    tick();
    drive(W_J, 32'h0000_0108);
    n_cmp++; if (bus.IR_RF !== 32'h0) begin n_bad++; $display("FAIL beq_nop_c3: got %h want 0", bus.IR_RF); end
    n_cmp++; if (bus.PC4_RF !== 32'h0000_0100) begin n_bad++; $display("FAIL beq_pc4_held_c3: got %h want %h", bus.PC4_RF, 32'h100); end
    n_cmp++; if (bus.J_IF !== 1'b1) begin n_bad++; $display("FAIL beq_run_c3: got %b want 1", bus.J_IF); end
    tick();
    n_cmp++; if (bus.IR_RF !== W_J) begin n_bad++; $display("FAIL beq_after_c4: got %h want %h", bus.IR_RF, W_J); end
  endtask

  task automatic test_jr();
    drive(W_JR, 32'h0000_0200);
    n_cmp++; if (bus.JR_IF !== 1'b1) begin n_bad++; $display("FAIL jr_if_c0: got %b want 1", bus.JR_IF); end
    tick();
    drive(W_LW, 32'h0000_0204);
    n_cmp++; if (bus.JR_RF !== 1'b1) begin n_bad++; $display("FAIL jr_rf_c1: got %b want 1", bus.JR_RF); end
    n_cmp++; if (bus.LW_IF !== 1'b0) begin n_bad++; $display("FAIL jr_if_masked_c1: got %b want 0", bus.LW_IF); end
    tick();
    drive(W_ADD, 32'h0000_0300);
    n_cmp++; if (bus.IR_RF !== 32'h0) begin n_bad++; $display("FAIL jr_nop_c2: got %h want 0", bus.IR_RF); end
    n_cmp++; if (bus.JR_RF !== 1'b0) begin n_bad++; $display("FAIL jr_rf_c2: got %b want 0", bus.JR_RF); end
    tick();
    n_cmp++; if (bus.IR_RF !== W_ADD) begin n_bad++; $display("FAIL jr_next_c3: got %h want %h", bus.IR_RF, W_ADD); end
    n_cmp++; if (bus.PC4_RF !== 32'h0000_0300) begin n_bad++; $display("FAIL jr_pc4_c3: got %h want %h", bus.PC4_RF, 32'h300); end
  endtask

  task automatic test_lw();
    drive(W_LW, 32'h0000_0010);
    n_cmp++; if (bus.LW_IF !== 1'b1) begin n_bad++; $display("FAIL lw_if_c0: got %b want 1", bus.LW_IF); end
    tick();
    drive(W_ADD, 32'h0000_0014);
    n_cmp++; if (bus.IR_RF !== W_LW) begin n_bad++; $display("FAIL lw_ir_rf_c1: got %h want %h", bus.IR_RF, W_LW); end
    n_cmp++; if (bus.LW_IF !== 1'b0) begin n_bad++; $display("FAIL lw_if_c1: got %b want 0", bus.LW_IF); end
    tick();
    n_cmp++; if (bus.IR_RF !== 32'h0) begin n_bad++; $display("FAIL lw_nop_c2: got %h want 0", bus.IR_RF); end
    n_cmp++; if (bus.IR_EX !== W_LW) begin n_bad++; $display("FAIL lw_ex_c2: got %h want %h", bus.IR_EX, W_LW); end
    tick();
    n_cmp++; if (bus.IR_RF !== W_ADD) begin n_bad++; $display("FAIL lw_add_c3: got %h want %h", bus.IR_RF, W_ADD); end
    n_cmp++; if (bus.IR_EX !== 32'h0) begin n_bad++; $display("FAIL lw_ex_nop_c3: got %h want 0", bus.IR_EX); end
  endtask

  task automatic test_jal();
    drive(W_JAL, 32'h0000_0024);
    n_cmp++; if (bus.JAL_IF !== 1'b1) begin n_bad++; $display("FAIL jal_if_c0: got %b want 1", bus.JAL_IF); end
    tick();
    drive(W_ADD, 32'h0000_0044);
    n_cmp++; if (bus.PC4_RF !== 32'h0000_0024) begin n_bad++; $display("FAIL jal_pc4_c1: got %h want %h", bus.PC4_RF, 32'h24); end
    n_cmp++; if (bus.IR_RF !== W_JAL) begin n_bad++; $display("FAIL jal_ir_rf_c1: got %h want %h", bus.IR_RF, W_JAL); end
    tick();
    n_cmp++; if (bus.IR_RF !== W_ADD) begin n_bad++; $display("FAIL jal_no_bubble_c2: got %h want %h", bus.IR_RF, W_ADD); end
    n_cmp++; if (bus.IR_EX !== W_JAL) begin n_bad++; $display("FAIL jal_ex_c2: got %h want %h", bus.IR_EX, W_JAL); end
  endtask

  task automatic test_undefined();
    drive(W_UND, 32'h0000_0050);
    n_cmp++; if ({bus.BEQ_IF, bus.BNE_IF, bus.J_IF, bus.JAL_IF, bus.JR_IF, bus.LW_IF} !== 6'b0) begin
      n_bad++; $display("FAIL und_flags: got %b want 000000", {bus.BEQ_IF, bus.BNE_IF, bus.J_IF, bus.JAL_IF, bus.JR_IF, bus.LW_IF});
    end
    tick();
    drive(W_ADD, 32'h0000_0054);
    n_cmp++; if (bus.IR_RF !== W_UND) begin n_bad++; $display("FAIL und_ir_rf: got %h want %h", bus.IR_RF, W_UND); end
    tick();
    n_cmp++; if (bus.IR_RF !== W_ADD) begin n_bad++; $display("FAIL und_no_bubble: got %h want %h", bus.IR_RF, W_ADD); end
    n_cmp++; if (bus.imm_EX !== 16'h1234) begin n_bad++; $display("FAIL und_imm_ex: got %h want 1234", bus.imm_EX); end
  endtask

  task automatic test_back_to_back();
    int nops;
    nops = 0;
    drive(W_BEQ, 32'h0000_0400);
    tick();
    drive(W_BNE, 32'h0000_0500);
    if (bus.IR_RF === 32'h0) nops++;
    tick();
    if (bus.IR_RF === 32'h0) nops++;
    n_cmp++; if (bus.BNE_IF !== 1'b0) begin n_bad++; $display("FAIL b2b_masked_c2: got %b want 0", bus.BNE_IF); end
    tick();
    if (bus.IR_RF === 32'h0) nops++;
    n_cmp++; if (bus.BNE_IF !== 1'b1) begin n_bad++; $display("FAIL b2b_run_c3: got %b want 1", bus.BNE_IF); end
    tick();
    drive(W_ADD, 32'h0000_0504);
    if (bus.IR_RF === 32'h0) nops++;
    n_cmp++; if (bus.BNE_RF !== 1'b1) begin n_bad++; $display("FAIL b2b_bne_rf_c4: got %b want 1", bus.BNE_RF); end
    n_cmp++; if (bus.PC4_RF !== 32'h0000_0500) begin n_bad++; $display("FAIL b2b_pc4_c4: got %h want %h", bus.PC4_RF, 32'h500); end
    for (int c = 5; c <= 7; c++) begin
      tick();
      if (bus.IR_RF === 32'h0) nops++;
    end
    n_cmp++; if (bus.IR_RF !== W_ADD) begin n_bad++; $display("FAIL b2b_add_c7: got %h want %h", bus.IR_RF, W_ADD); end
    n_cmp++; if (nops !== 4) begin n_bad++; $display("FAIL b2b_nop_count: got %0d want 4", nops); end
  endtask

  task automatic test_reset_in_hold();
    drive(W_BEQ, 32'h0000_0600);
    tick();
    drive(W_ADD, 32'h0000_0604);
    n_cmp++; if (bus.BEQ_RF !== 1'b1) begin n_bad++; $display("FAIL rsth_pre_beq_rf: got %b want 1", bus.BEQ_RF); end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.IR_RF !== 32'h0) begin n_bad++; $display("FAIL rsth_ir_rf: got %h want 0", bus.IR_RF); end
    n_cmp++; if (bus.IR_EX !== 32'h0) begin n_bad++; $display("FAIL rsth_ir_ex: got %h want 0", bus.IR_EX); end
    n_cmp++; if (bus.PC4_RF !== 32'h0) begin n_bad++; $display("FAIL rsth_pc4: got %h want 0", bus.PC4_RF); end
    n_cmp++; if ({bus.BEQ_RF, bus.BNE_RF, bus.JR_RF, bus.BEQ_EX, bus.BNE_EX, bus.imm_EX} !== 21'b0) begin
      n_bad++; $display("FAIL rsth_flags: got %b want 0", {bus.BEQ_RF, bus.BNE_RF, bus.JR_RF, bus.BEQ_EX, bus.BNE_EX, bus.imm_EX});
    end
    reset = 1'b0;
    drive(W_LW, 32'h0000_0080);
    n_cmp++; if (bus.LW_IF !== 1'b1) begin n_bad++; $display("FAIL rsth_run_after: got %b want 1", bus.LW_IF); end
    tick();
    n_cmp++; if (bus.IR_RF !== W_LW) begin n_bad++; $display("FAIL rsth_first_edge: got %h want %h", bus.IR_RF, W_LW); end
    n_cmp++; if (bus.PC4_RF !== 32'h0000_0080) begin n_bad++; $display("FAIL rsth_pc4_after: got %h want %h", bus.PC4_RF, 32'h80); end
    drive(W_ADD, 32'h0000_0084);
    tick();
    tick();
  endtask

  initial begin
    bus.instr_IF = 32'h0;
    bus.PC_plus_four_IF = 32'h0;
    test_reset();
    test_beq();
    test_jr();
    test_lw();
    test_jal();
    test_undefined();
    test_back_to_back();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
